// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//            direction counters. Sits in the fetch stage ahead of the PC
//            register. It predicts the next PC from the current fetch PC,
//            detects mispredicts reported by decode, and trains its table.
//
// Ports    : clk_i                  clock
//            rst_i                  synchronous active-high reset
//            if_predict_pc_i        fetch PC to look up
//            if_predict_targetPc_o  predicted next PC (pc+4 on miss)
//            if_predict_taken_o     predicted taken
//            id_update_valid_i      decode holds a valid instruction
//            id_update_pc_i         PC of the decode instruction
//            id_is_branch_i         decode instruction is a branch/jump
//            id_actual_taken_i      resolved direction
//            id_actual_target_i     resolved target
//            id_pred_taken_i        prediction carried from fetch
//            id_pred_target_i       predicted target carried from fetch
//            if_predict_failed_o    mispredict, PC must redirect
//            id_update_targetPc_o   correct next PC for the decode instr
//
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor #(
    parameter int RegW  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic [RegW-1:0] if_predict_pc_i,
    output logic [RegW-1:0] if_predict_targetPc_o,
    output logic            if_predict_taken_o,

    input  logic            id_update_valid_i,
    input  logic [RegW-1:0] id_update_pc_i,
    input  logic            id_is_branch_i,
    input  logic            id_actual_taken_i,
    input  logic [RegW-1:0] id_actual_target_i,
    input  logic            id_pred_taken_i,
    input  logic [RegW-1:0] id_pred_target_i,
    output logic            if_predict_failed_o,
    output logic [RegW-1:0] id_update_targetPc_o
);

    localparam int c_ENTRIES = 2 ** IDX_W;
    localparam int c_TAG_W   = RegW - IDX_W - 2;
    localparam int c_TGT_W   = RegW - 2;

    localparam logic [c_TGT_W-1:0] c_WORD_ONE = {{(c_TGT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]         c_CTR_MAX  = 2'b11;
    localparam logic [1:0]         c_CTR_MIN  = 2'b00;
    localparam logic [1:0]         c_CTR_INIT = 2'b10;

    // ------------------------------------------------------------------
    // Table storage. Only the valid bits are reset; the payload is
    // meaningless while its valid bit is clear.
    // ------------------------------------------------------------------
    logic [c_ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0]   r_tag    [c_ENTRIES];
    logic [c_TGT_W-1:0]   r_target [c_ENTRIES];
    logic [1:0]           r_ctr    [c_ENTRIES];

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   w_l_idx;
    logic [c_TAG_W-1:0] w_l_tag;
    logic               w_l_hit;
    logic [RegW-1:0]    w_l_pc_plus4;

    assign w_l_idx = if_predict_pc_i[IDX_W+1:2];
    assign w_l_tag = if_predict_pc_i[RegW-1:IDX_W+2];

    // Reset masks the hit so stale entries cannot predict during the
    // reset cycle itself (the valid bits only clear on the edge).
    assign w_l_hit = r_valid[w_l_idx] & (r_tag[w_l_idx] == w_l_tag) & ~rst_i;

    // Increment the word address only; the byte offset passes through.
    assign w_l_pc_plus4 = {if_predict_pc_i[RegW-1:2] + c_WORD_ONE, if_predict_pc_i[1:0]};

    assign if_predict_taken_o    = w_l_hit & r_ctr[w_l_idx][1];
    assign if_predict_targetPc_o = w_l_hit ? {r_target[w_l_idx], 2'b00} : w_l_pc_plus4;

    // ------------------------------------------------------------------
    // Mispredict detection
    // ------------------------------------------------------------------
    logic            w_u_taken;
    logic            w_dir_wrong;
    logic            w_tgt_wrong;
    logic [RegW-1:0] w_u_pc_plus4;

    // A non-branch always resolves as not taken, so a BTB alias that
    // predicted taken on it is caught by the direction compare.
    assign w_u_taken   = id_is_branch_i & id_actual_taken_i;
    assign w_dir_wrong = w_u_taken != id_pred_taken_i;
    assign w_tgt_wrong = w_u_taken & (id_pred_target_i != id_actual_target_i);

    assign w_u_pc_plus4 = {id_update_pc_i[RegW-1:2] + c_WORD_ONE, id_update_pc_i[1:0]};

    assign if_predict_failed_o  = id_update_valid_i & ~rst_i & (w_dir_wrong | w_tgt_wrong);
    assign id_update_targetPc_o = w_u_taken ? id_actual_target_i : w_u_pc_plus4;

    // ------------------------------------------------------------------
    // Training decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]   w_u_idx;
    logic [c_TAG_W-1:0] w_u_tag;
    logic               w_u_hit;
    logic               w_train;
    logic               w_alloc;
    logic               w_inval;
    logic               w_ctr_inc;
    logic               w_ctr_dec;

    assign w_u_idx = id_update_pc_i[IDX_W+1:2];
    assign w_u_tag = id_update_pc_i[RegW-1:IDX_W+2];
    assign w_u_hit = r_valid[w_u_idx] & (r_tag[w_u_idx] == w_u_tag);
    assign w_train = id_update_valid_i & ~rst_i;

    always_comb begin
        w_alloc   = 1'b0;
        w_inval   = 1'b0;
        w_ctr_inc = 1'b0;
        w_ctr_dec = 1'b0;
        if (w_train) begin
            if (id_is_branch_i) begin
                if (w_u_hit) begin
                    w_ctr_inc = id_actual_taken_i;
                    w_ctr_dec = ~id_actual_taken_i;
                end else begin
                    // Not-taken misses are not allocated: a fresh entry
                    // would predict taken and be wrong immediately.
                    w_alloc = id_actual_taken_i;
                end
            end else begin
                w_inval = w_u_hit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table update. Writes land on the edge, so a same-cycle lookup of
    // the same index sees the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
        end else if (w_alloc) begin
            r_valid[w_u_idx] <= 1'b1;
        end else if (w_inval) begin
            r_valid[w_u_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= id_actual_target_i[RegW-1:2];
            r_ctr[w_u_idx]    <= c_CTR_INIT;
        end else if (w_ctr_inc) begin
            r_target[w_u_idx] <= id_actual_target_i[RegW-1:2];
            if (r_ctr[w_u_idx] != c_CTR_MAX) begin
                r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
            end
        end else if (w_ctr_dec) begin
            if (r_ctr[w_u_idx] != c_CTR_MIN) begin
                r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed self-checking bench for branch_predictor.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lk_pc;
    logic [31:0] lk_target;
    logic        lk_taken;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_br;
    logic        up_tk;
    logic [31:0] up_tgt;
    logic        up_ptk;
    logic [31:0] up_ptgt;
    logic        failed;
    logic [31:0] up_next;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.RegW(32), .IDX_W(4)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .if_predict_pc_i       (lk_pc),
        .if_predict_targetPc_o (lk_target),
        .if_predict_taken_o    (lk_taken),
        .id_update_valid_i     (up_valid),
        .id_update_pc_i        (up_pc),
        .id_is_branch_i        (up_br),
        .id_actual_taken_i     (up_tk),
        .id_actual_target_i    (up_tgt),
        .id_pred_taken_i       (up_ptk),
        .id_pred_target_i      (up_ptgt),
        .if_predict_failed_o   (failed),
        .id_update_targetPc_o  (up_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after
    // the rising edge, well clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        up_valid = 1'b1;
        up_pc    = pc;
        up_br    = br;
        up_tk    = tk;
        up_tgt   = tgt;
        up_ptk   = ptk;
        up_ptgt  = ptgt;
        #1;
    endtask

    task automatic clr_upd();
        up_valid = 1'b0;
        up_br    = 1'b0;
        up_tk    = 1'b0;
        up_ptk   = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        lk_pc = 32'h1c00_0000;
        // Reset must mask a would-be mispredict.
        set_upd(32'h1c00_0000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        n_checks++;
        if (failed !== 1'b0) begin n_fail++; $display("FAIL reset_failed: got %b expected 0", failed); end
        tick();
        tick();
        rst = 1'b0;
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL post_reset_taken: got %b expected 0", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0004) begin n_fail++; $display("FAIL post_reset_target: got %h expected 1c000004", lk_target); end
        n_checks++;
        if (failed !== 1'b0) begin n_fail++; $display("FAIL post_reset_failed: got %b expected 0", failed); end
    endtask

    task automatic test_allocate();
        set_upd(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0100, 1'b0, 32'h0);
        n_checks++;
        if (failed !== 1'b1) begin n_fail++; $display("FAIL alloc_failed: got %b expected 1", failed); end
        n_checks++;
        if (up_next !== 32'h1c00_0100) begin n_fail++; $display("FAIL alloc_next: got %h expected 1c000100", up_next); end
        tick();
        clr_upd();
        lk_pc = 32'h1c00_0010;
        #1;
        n_checks++;
        if (lk_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_hit_taken: got %b expected 1", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0100) begin n_fail++; $display("FAIL alloc_hit_target: got %h expected 1c000100", lk_target); end
    endtask

    task automatic test_counter();
        lk_pc = 32'h1c00_0010;
        // ctr 2 -> 1 ; predicted taken but resolved not taken.
        set_upd(32'h1c00_0010, 1'b1, 1'b0, 32'h1c00_0100, 1'b1, 32'h1c00_0100);
        n_checks++;
        if (failed !== 1'b1) begin n_fail++; $display("FAIL nt_failed: got %b expected 1", failed); end
        n_checks++;
        if (up_next !== 32'h1c00_0014) begin n_fail++; $display("FAIL nt_next: got %h expected 1c000014", up_next); end
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL ctr1_taken: got %b expected 0", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0100) begin n_fail++; $display("FAIL ctr1_target: got %h expected 1c000100", lk_target); end
        // ctr 1 -> 0, then 0 stays 0.
        set_upd(32'h1c00_0010, 1'b1, 1'b0, 32'h1c00_0100, 1'b0, 32'h1c00_0100);
        n_checks++;
        if (failed !== 1'b0) begin n_fail++; $display("FAIL nt_correct_failed: got %b expected 0", failed); end
        tick();
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL ctr0_taken: got %b expected 0", lk_taken); end
        // ctr 0 -> 1: still not taken (would be taken had 0 wrapped to 3).
        set_upd(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0100, 1'b0, 32'h1c00_0100);
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_sat0_taken: got %b expected 0", lk_taken); end
        // ctr 1 -> 2.
        set_upd(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0100, 1'b0, 32'h1c00_0100);
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b1) begin n_fail++; $display("FAIL ctr2_taken: got %b expected 1", lk_taken); end
        // ctr 2 -> 3 -> 3 with a new target; correct direction, wrong target.
        set_upd(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0200, 1'b1, 32'h1c00_0100);
        n_checks++;
        if (failed !== 1'b1) begin n_fail++; $display("FAIL tgt_wrong_failed: got %b expected 1", failed); end
        tick();
        tick();
        clr_upd();
        n_checks++;
        if (lk_target !== 32'h1c00_0200) begin n_fail++; $display("FAIL retarget: got %h expected 1c000200", lk_target); end
        // ctr 3 -> 2: taken (would be not taken had 3 wrapped to 0).
        set_upd(32'h1c00_0010, 1'b1, 1'b0, 32'h1c00_0200, 1'b1, 32'h1c00_0200);
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_sat3_taken: got %b expected 1", lk_taken); end
        // Correctly predicted taken with correct target: no mispredict.
        set_upd(32'h1c00_0010, 1'b1, 1'b1, 32'h1c00_0200, 1'b1, 32'h1c00_0200);
        n_checks++;
        if (failed !== 1'b0) begin n_fail++; $display("FAIL correct_taken_failed: got %b expected 0", failed); end
        tick();
        clr_upd();
    endtask

    task automatic test_alias();
        lk_pc = 32'h1c00_0010;
        set_upd(32'h1c00_0410, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1c00_0200);
        n_checks++;
        if (failed !== 1'b1) begin n_fail++; $display("FAIL alias_failed: got %b expected 1", failed); end
        n_checks++;
        if (up_next !== 32'h1c00_0414) begin n_fail++; $display("FAIL alias_next: got %h expected 1c000414", up_next); end
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b1) begin n_fail++; $display("FAIL alias_retained_taken: got %b expected 1", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0200) begin n_fail++; $display("FAIL alias_retained_target: got %h expected 1c000200", lk_target); end
        set_upd(32'h1c00_0010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1c00_0200);
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL inval_taken: got %b expected 0", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0014) begin n_fail++; $display("FAIL inval_target: got %h expected 1c000014", lk_target); end
    endtask

    task automatic test_same_cycle();
        lk_pc = 32'h1c00_0020;
        set_upd(32'h1c00_0020, 1'b1, 1'b1, 32'h1c00_0300, 1'b0, 32'h0);
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_taken: got %b expected 0", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0024) begin n_fail++; $display("FAIL same_cycle_target: got %h expected 1c000024", lk_target); end
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b1) begin n_fail++; $display("FAIL after_write_taken: got %b expected 1", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0300) begin n_fail++; $display("FAIL after_write_target: got %h expected 1c000300", lk_target); end
    endtask

    task automatic test_not_taken_miss();
        lk_pc = 32'h1c00_0040;
        set_upd(32'h1c00_0040, 1'b1, 1'b0, 32'h1c00_0500, 1'b0, 32'h0);
        n_checks++;
        if (failed !== 1'b0) begin n_fail++; $display("FAIL nt_miss_failed: got %b expected 0", failed); end
        tick();
        clr_upd();
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL nt_miss_noalloc: got %b expected 0", lk_taken); end
    endtask

    task automatic test_reset_mid_training();
        // The entry at 0x1c000020 is live; reset must hide it this cycle.
        lk_pc = 32'h1c00_0020;
        rst   = 1'b1;
        set_upd(32'h1c00_0030, 1'b1, 1'b1, 32'h1c00_0400, 1'b0, 32'h0);
        n_checks++;
        if (failed !== 1'b0) begin n_fail++; $display("FAIL rst_mid_failed: got %b expected 0", failed); end
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL rst_mid_taken: got %b expected 0", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0024) begin n_fail++; $display("FAIL rst_mid_target: got %h expected 1c000024", lk_target); end
        tick();
        rst = 1'b0;
        clr_upd();
        lk_pc = 32'h1c00_0030;
        #1;
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL rst_noalloc_taken: got %b expected 0", lk_taken); end
        n_checks++;
        if (lk_target !== 32'h1c00_0034) begin n_fail++; $display("FAIL rst_noalloc_target: got %h expected 1c000034", lk_target); end
        lk_pc = 32'h1c00_0020;
        #1;
        n_checks++;
        if (lk_taken !== 1'b0) begin n_fail++; $display("FAIL rst_cleared_taken: got %b expected 0", lk_taken); end
    endtask

    task automatic test_wrap();
        lk_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if (lk_target !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_lookup: got %h expected 00000000", lk_target); end
        lk_pc = 32'h1c00_0002;
        #1;
        n_checks++;
        if (lk_target !== 32'h1c00_0006) begin n_fail++; $display("FAIL lowbits_lookup: got %h expected 1c000006", lk_target); end
        set_upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1c00_0000);
        n_checks++;
        if (up_next !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next: got %h expected 00000000", up_next); end
        n_checks++;
        if (failed !== 1'b1) begin n_fail++; $display("FAIL wrap_failed: got %b expected 1", failed); end
        // Non-branch predicted not taken: no mispredict.
        up_ptk = 1'b0;
        #1;
        n_checks++;
        if (failed !== 1'b0) begin n_fail++; $display("FAIL nonbr_ok_failed: got %b expected 0", failed); end
        tick();
        clr_upd();
    endtask

    initial begin
        rst      = 1'b1;
        lk_pc    = 32'h0;
        up_valid = 1'b0;
        up_pc    = 32'h0;
        up_br    = 1'b0;
        up_tk    = 1'b0;
        up_tgt   = 32'h0;
        up_ptk   = 1'b0;
        up_ptgt  = 32'h0;
        #1;
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_same_cycle();
        test_not_taken_miss();
        test_reset_mid_training();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, in the fetch stage directly upstream of the PC register. It looks up the current fetch PC combinationally and returns a predicted target and taken flag for next-PC selection. One cycle later in the pipeline, decode (ID) returns the resolved branch outcome. The block then flags a mispredict, supplies the corrected next PC, and trains its table.

## Interface
- `RegW`, default `32`: address/data width (codebase `RegW`).
- `IDX_W`, default `4`: index bits; the table has `2**IDX_W` entries.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `if_predict_pc_i`, in, RegW: current fetch PC to look up.
- `if_predict_targetPc_o`, out, RegW: predicted next PC.
- `if_predict_taken_o`, out, 1: predict taken.
- `id_update_valid_i`, in, 1: the ID stage holds a valid instruction this cycle.
- `id_update_pc_i`, in, RegW: PC of the instruction in ID.
- `id_is_branch_i`, in, 1: the ID instruction is a branch or jump.
- `id_actual_taken_i`, in, 1: resolved direction.
- `id_actual_target_i`, in, RegW: resolved branch target.
- `id_pred_taken_i`, in, 1: prediction carried with the instruction from IF.
- `id_pred_target_i`, in, RegW: predicted target carried with the instruction from IF.
- `if_predict_failed_o`, out, 1: mispredict; PC must redirect.
- `id_update_targetPc_o`, out, RegW: correct next PC for the ID instruction.

Clock and reset: one clock `clk_i`; reset `rst_i` is synchronous and active-high.

## Operation

**Table entry contents.** Each entry holds:
- `valid` (1 bit)
- `tag`: `pc[RegW-1:IDX_W+2]`
- `target`: `[RegW-1:2]`, with low bits implied `00`
- `ctr` (2 bits)

**Indexing.** Index is `pc[IDX_W+1:2]`.

**Lookup (combinational, from registered table).**
- `hit` = `valid[idx] & tag[idx]==if_predict_pc_i[RegW-1:IDX_W+2]`.
- `if_predict_taken_o` = `hit & ctr[1]`.
- `if_predict_targetPc_o`:
  - on hit: `{target,2'b00}`;
  - on miss: `if_predict_pc_i+4`, computed over `[RegW-1:2]` with low 2 bits passed through and wrapping modulo 2^RegW.

**Mispredict detect (combinational).**
- `if_predict_failed_o` = `id_update_valid_i & ~rst_i & (`
  - `(id_is_branch_i & id_actual_taken_i) != id_pred_taken_i`
  - `| (id_is_branch_i & id_actual_taken_i & id_pred_target_i != id_actual_target_i) )`.
- `id_update_targetPc_o` = `id_actual_taken_i & id_is_branch_i ? id_actual_target_i : id_update_pc_i+4`. It is always driven; it is meaningful only when failed=1.
- A non-branch that was predicted taken (BTB alias) is a mispredict, and its correction is `pc+4`.

**Training.** Training happens on a posedge with `id_update_valid_i & ~rst_i`, at index `u` from `id_update_pc_i`, where update hit = `valid[u] & tag match`.

- **Branch, update hit:**
  - `ctr` increments saturating at 3 if taken, decrements saturating at 0 if not taken.
  - If taken, `target` is overwritten with the actual target.
- **Branch, update miss, taken:**
  - Allocate (overwrite any occupant): `valid=1`, new `tag`, `target`, `ctr=2'b10`.
- **Branch, update miss, not taken:** no write.
- **Non-branch, update hit:** clear `valid[u]`.
- **Non-branch, update miss:** no write.

## Timing

**Reset.**
- Reset clears all `valid` bits; `ctr`, `tag` and `target` become don't-care.
- For the whole cycle in which `rst_i`=1, and the cycle after reset deasserts:
  - `if_predict_taken_o`=0;
  - `if_predict_targetPc_o`=`if_predict_pc_i+4`;
  - `if_predict_failed_o`=0 while `rst_i`=1.
- Reset has priority over training.

**Latency.**
- Lookup is zero-cycle (same cycle as `if_predict_pc_i`).
- Mispredict output is zero-cycle from the ID inputs.
- A table write becomes visible to lookup on the cycle after the training edge.

**Simultaneous lookup and update.**
- When lookup index equals update index in the same cycle, lookup returns the pre-update contents; there is no bypass.

**No stall coupling.**
- Training occurs every cycle in which `id_update_valid_i`=1.
- The ID stage must present each instruction with valid=1 for exactly one cycle, or repeat only idempotent information.
  - Counters are not idempotent: a held ID instruction must drop `id_update_valid_i` after its first cycle.

**Wrap-around.**
- `pc+4` of `32'hFFFF_FFFC` gives `32'h0000_0000`.
- Counter saturation: 3 stays at 3 on taken; 0 stays at 0 on not taken.

## Test plan
1. **Post-reset lookup.** Hold reset 2 cycles, release, look up `0x1c000000` → taken=0, target=`0x1c000004`, failed=0.
2. **Taken-miss allocate, then hit.**
   - Update pc=`0x1c000010`, branch, taken, target=`0x1c000100`, pred_taken=0 → failed=1 and `id_update_targetPc_o`=`0x1c000100` that cycle.
   - Next cycle, lookup `0x1c000010` → taken=1, target=`0x1c000100`.
3. **Counter training and saturation.**
   - From ctr=2, apply two not-taken updates at `0x1c000010` → lookup taken=0 (ctr=0).
   - Apply a third not-taken update → ctr stays 0.
   - Apply two taken updates → taken=1.
4. **Alias and non-branch invalidation.**
   - Update pc=`0x1c000410` (same index, different tag), non-branch, pred_taken=1 → failed=1, `id_update_targetPc_o`=`0x1c000414`.
   - This is a tag miss, so the entry is retained and lookup `0x1c000010` still hits.
   - Repeat with pc=`0x1c000010` as a non-branch → next lookup taken=0.
5. **Same-cycle read/write.** Lookup and allocate the same index in one cycle → the lookup shows the old value (miss); the following cycle shows the hit.
6. **Reset mid-training.** Assert `rst_i` in the same cycle as a taken update → no allocation, failed=0, and the next lookup misses.
